// File: rtl/muldiv_unit_pkg.sv
// Execute-stage types for the multiply/divide unit (package pipes).
// Optional build macro consumed by the unit: MULDIV_FAST_MUL_EN.
package pipes;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_signed(input muldiv_op_t op);
    logic sgn_s;
    case (op)
      OP_MULT, OP_DIV: sgn_s = 1'b1;
      default:         sgn_s = 1'b0;
    endcase
    return sgn_s;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Trial subtraction and restore select.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = shifted_s - {2'b00, divisor};
    if (shifted_s >= {2'b00, divisor}) begin
      q_bit   = 1'b1;
      rem_out = diff_s[WIDTH:0];
    end else begin
      q_bit   = 1'b0;
      rem_out = shifted_s[WIDTH:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-pass combinational multiply.
module muldiv_unit
  import pipes::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_CW   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  muldiv_state_t      state_r;
  logic [CW-1:0]      count_r;
  logic               busy_r, done_r, dbz_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               is_div_r, dz_r, neg_lo_r, neg_hi_r;
  logic [WIDTH-1:0]   b_r, a_raw_r;
  // Multiply: {partial product, remaining multiplier}; divide: low half is dividend/quotient.
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH:0]     rem_r;

  logic               signed_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_rem_s;
  logic               div_q_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, remd_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (rem_r),
    .dividend_bit (acc_r[WIDTH-1]),
    .divisor      (b_r),
    .rem_out      (div_rem_s),
    .q_bit        (div_q_s)
  );

  // Operand magnitudes, shift-add step and sign fixup of the finished result.
  always_comb begin
    signed_s  = op_is_signed(op);
    mag_a_s   = magnitude(src_a, signed_s);
    mag_b_s   = magnitude(src_b, signed_s);
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    prod_s    = neg_lo_r ? (~acc_r + ONE_2W) : acc_r;
    quot_s    = neg_lo_r ? (~acc_r[WIDTH-1:0] + ONE_W) : acc_r[WIDTH-1:0];
    remd_s    = neg_hi_r ? (~rem_r[WIDTH-1:0] + ONE_W) : rem_r[WIDTH-1:0];
  end

  // Control FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      count_r  <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      dz_r     <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      b_r      <= {WIDTH{1'b0}};
      a_raw_r  <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      rem_r    <= {(WIDTH+1){1'b0}};
    end else if (flush) begin
      state_r <= ST_IDLE;
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi_r <= src_a;
              OP_MTLO: lo_r <= src_a;
              OP_MULT, OP_MULTU: begin
                is_div_r <= 1'b0;
                b_r      <= mag_b_s;
                neg_lo_r <= signed_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_hi_r <= 1'b0;
                busy_r   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                acc_r    <= {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
                state_r  <= ST_FIXUP;
`else
                acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
                count_r  <= CNT_LOAD;
                state_r  <= ST_CALC;
`endif
              end
              OP_DIV, OP_DIVU: begin
                is_div_r <= 1'b1;
                b_r      <= mag_b_s;
                a_raw_r  <= src_a;
                dz_r     <= (src_b == {WIDTH{1'b0}});
                neg_lo_r <= signed_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_hi_r <= signed_s & src_a[WIDTH-1];
                acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
                rem_r    <= {(WIDTH+1){1'b0}};
                count_r  <= CNT_LOAD;
                busy_r   <= 1'b1;
                state_r  <= ST_CALC;
              end
              default: state_r <= ST_IDLE;
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (is_div_r) begin
            rem_r             <= div_rem_s;
            acc_r[WIDTH-1:0]  <= {acc_r[WIDTH-2:0], div_q_s};
          end else begin
            acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
          end
          if (count_r == {CW{1'b0}}) begin
            state_r <= ST_FIXUP;
          end else begin
            count_r <= count_r - ONE_CW;
          end
        end
        ST_FIXUP: begin
          if (!is_div_r) begin
            {hi_r, lo_r} <= prod_s;
          end else if (dz_r) begin
            lo_r  <= {WIDTH{1'b1}};
            hi_r  <= a_raw_r;
            dbz_r <= 1'b1;
          end else begin
            lo_r <= quot_s;
            hi_r <= remd_s;
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the execute stage of the five-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle. It exposes `busy` so the hazard unit can stall MFHI/MFLO and a following multiply or divide.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width; must be ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe from execute; sampled only when `busy`=0.
- `op`  in  3  `muldiv_op_t`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `src_a`  in  WIDTH  rs value: multiplicand or dividend, or the value to move.
- `src_b`  in  WIDTH  rt value: multiplier or divisor.
- `flush`  in  1  abort any in-flight operation (exception or squash).
- `busy`  out  1  registered; high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a MULT/DIV result lands in HI/LO.
- `div_by_zero`  out  1  pulses together with `done` for a DIV/DIVU with `src_b`=0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **FSM states:** IDLE, CALC, FIXUP.
- **IDLE + start + MTHI/MTLO:** `hi` or `lo` ← `src_a` at the next edge. Stay IDLE. No `done`, no `busy`.
- **IDLE + start + MULT/MULTU/DIV/DIVU:**
  - Latch the op and a signed flag.
  - For signed ops, latch operand magnitudes and record the result signs:
    - product sign = sign(a) xor sign(b)
    - quotient sign = sign(a) xor sign(b)
    - remainder sign = sign(a)
  - Load counter with WIDTH−1 and go to CALC.
- **CALC multiply:** shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **CALC divide:** restoring division, one quotient bit per cycle. Remainder register is WIDTH+1 bits.
- **CALC exit:** when the counter reaches 0, go to FIXUP.
- **FIXUP:**
  - Apply two's-complement negation per the recorded signs.
  - Write `hi`/`lo`:
    - multiply: hi = upper half, lo = lower half of the product
    - divide: lo = quotient, hi = remainder
  - Go to IDLE. Assert `done` for the following cycle.
- **Arithmetic rules:**
  - Negation wraps modulo 2^WIDTH.
  - DIV of the most negative value by −1 gives lo = 0x80000000, hi = 0 (WIDTH=32). No trap.
- **Divide by zero (signed or unsigned):**
  - lo = all ones, hi = `src_a` unmodified; sign fixup is skipped.
  - Full latency still applies; `div_by_zero` pulses with `done`.
- **Boundary conditions:**
  - `start` while `busy`: ignored; `hi`/`lo` and the in-flight op are unaffected.
  - `flush` in any state: IDLE at the next edge, `hi`/`lo` unchanged, no `done`.
  - `flush` and `start` in the same cycle: flush wins and the start is dropped.
  - MTHI/MTLO together with `done`-producing FIXUP cannot coincide, because `start` is ignored while `busy`.
- **Reset (asynchronous, any time including mid-operation):** `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, state IDLE, counter 0.

## Timing
- `start` is accepted in cycle 0.
- `busy` is high in cycles 1..WIDTH+1: CALC for WIDTH cycles, then FIXUP in cycle WIDTH+1.
- `done`, `div_by_zero` and the new `hi`/`lo` are visible in cycle WIDTH+2. For WIDTH=32 that is cycle 34.
- Next start is accepted no earlier than cycle WIDTH+2.
- MTHI/MTLO: the new value is visible in cycle 1.
- `busy` is registered. The hazard unit must OR in `start & (op is MULT/DIV)` to stall a dependent instruction in cycle 0.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:**
  - MULT/MULTU compute the full product combinationally at accept.
  - The FSM goes IDLE→FIXUP directly: `busy` in cycle 1 only, `done` in cycle 2.
  - Division is unchanged.
- **Undefined:** multiply is iterative as above, with no multiplier inferred.

## Structure
- `muldiv_op_t` (3-bit enum) and `muldiv_state_t` belong in the `pipes` package, next to the stage register types.
- The execute-stage register carries `op` and the start strobe.
- One sub-module, `restoring_div_step`: combinational single iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once.

## Test plan
All scenarios use WIDTH=32.
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `busy` cycles 1–33; `done` only in cycle 34.
2. MULT 0xFFFFFFFD (−3) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. With `MULDIV_FAST_MUL_EN`, same result with `done` in cycle 2.
3. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5; `div_by_zero` and `done` pulse together in cycle 34.
5. MTHI 0x1234, then DIVU 100/7 flushed in cycle 10 → no `done`, `busy` low from cycle 11, hi stays 0x1234. A `start` issued in cycle 5 is ignored.
6. Reset deasserted→asserted in cycle 20 of MULT → all outputs 0 immediately. After release, a new MTLO 0xA5A5A5A5 gives lo=0xA5A5A5A5 one cycle later.
